// File: rtl/trigg_frame_pkg.sv
// Shared types and constants for the trigger-timestamp frame receiver.
package trigg_frame_pkg;

  localparam int N_CH          = 4;
  localparam int TS_W          = 32;
  localparam int PAYLOAD_BYTES = 16;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } trigg_frame_state_e;

  // Shadow holds channels in arrival order from the MSB end; ch0 lands at [31:0].
  function automatic logic [N_CH*TS_W-1:0] remap_channels(
    input logic [N_CH*TS_W-1:0] shadow
  );
    logic [N_CH*TS_W-1:0] ts;
    ts = '0;
    for (int k = 0; k < N_CH; k++) begin
      ts[k*TS_W +: TS_W] = shadow[(N_CH-1-k)*TS_W +: TS_W];
    end
    return ts;
  endfunction

endpackage

// File: rtl/trigg_frame_timer.sv
// Inter-byte idle counter; o_hit is the combinational expiry, o_expire its registered pulse.
module trigg_frame_timer #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_active,
  input  logic i_rx_dv,
  output logic o_hit,
  output logic o_expire
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // A byte arriving on the terminal cycle suppresses the expiry.
  always_comb begin
    o_hit    = i_active && !i_rx_dv && (cnt_q == CNT_LAST);
    expire_d = o_hit;
    if (!i_active || i_rx_dv || o_hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign o_expire = expire_q;

endmodule

// File: rtl/trigg_frame_rx.sv
// Sync-hunting frame decoder for the 4-channel timestamp UART link.
// Optional inter-byte timeout is built only when TRIGG_FRAME_TIMEOUT_EN is defined.
module trigg_frame_rx
  import trigg_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
`ifdef TRIGG_FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 10000
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_rx_dv,
  input  logic [7:0]             i_rx_byte,
  output logic [N_CH*TS_W-1:0]   o_ts,
  output logic                   o_frame_valid,
  output logic                   o_chk_err,
  output logic                   o_timeout_err,
  output logic [15:0]            o_frame_cnt
);

  trigg_frame_state_e    state_q, state_d;
  logic [N_CH*TS_W-1:0]  shadow_q, shadow_d;
  logic [N_CH*TS_W-1:0]  ts_q, ts_d;
  logic [7:0]            chk_q, chk_d;
  logic [4:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  chk_err_q, chk_err_d;
  logic                  timeout_hit;

`ifdef TRIGG_FRAME_TIMEOUT_EN
  trigg_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_active (state_q != HUNT),
    .i_rx_dv  (i_rx_dv),
    .o_hit    (timeout_hit),
    .o_expire (o_timeout_err)
  );
`else
  assign timeout_hit   = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    ts_d          = ts_q;
    chk_d         = chk_q;
    byte_cnt_d    = byte_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frame_valid_d = 1'b0;
    chk_err_d     = 1'b0;

    if (i_rx_dv) begin
      unique case (state_q)
        HUNT: begin
          if (i_rx_byte == SYNC_BYTE) begin
            byte_cnt_d = '0;
            chk_d      = '0;
            state_d    = PAYLOAD;
          end
        end
        // Sync-valued bytes here are payload data; no resync mid-frame.
        PAYLOAD: begin
          shadow_d   = {shadow_q[N_CH*TS_W-9:0], i_rx_byte};
          chk_d      = chk_q ^ i_rx_byte;
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (byte_cnt_q == 5'(PAYLOAD_BYTES - 1)) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (i_rx_byte == chk_q) begin
            ts_d          = remap_channels(shadow_q);
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (timeout_hit) begin
      state_d = HUNT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      ts_q          <= '0;
      chk_q         <= '0;
      byte_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      ts_q          <= ts_d;
      chk_q         <= chk_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_valid_q <= frame_valid_d;
      chk_err_q     <= chk_err_d;
    end
  end

  assign o_ts          = ts_q;
  assign o_frame_valid = frame_valid_q;
  assign o_chk_err     = chk_err_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_trigg_frame_rx.sv
// Directed self-checking bench for trigg_frame_rx (timeout test adapts to TRIGG_FRAME_TIMEOUT_EN).
module tb_trigg_frame_rx;

  localparam int TO = 10000;
  localparam logic [127:0] F1_TS = 128'h00000004_00000003_00000002_00000001;

  logic         clk;
  logic         reset_n;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic [127:0] ts;
  logic         frame_valid;
  logic         chk_err;
  logic         timeout_err;
  logic [15:0]  frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int tot_valid = 0, tot_chk = 0, tot_to = 0, tot_multi = 0;
  int s_valid, s_chk, s_to;

  trigg_frame_rx dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_rx_dv       (rx_dv),
    .i_rx_byte     (rx_byte),
    .o_ts          (ts),
    .o_frame_valid (frame_valid),
    .o_chk_err     (chk_err),
    .o_timeout_err (timeout_err),
    .o_frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    tot_valid += int'(frame_valid);
    tot_chk   += int'(chk_err);
    tot_to    += int'(timeout_err);
    if ((int'(frame_valid) + int'(chk_err) + int'(timeout_err)) > 1) tot_multi++;
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic snap();
    s_valid = tot_valid;
    s_chk   = tot_chk;
    s_to    = tot_to;
  endtask

  // Called at a negedge; returns at the negedge after the byte is sampled plus gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  // Checksum byte is always sent last with no trailing gap so the caller can check latency.
  task automatic send_frame(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                            input logic [31:0] c3, input logic [7:0] ck, input int gap);
    send_byte(8'hA5, gap);
    send_word(c0, gap);
    send_word(c1, gap);
    send_word(c2, gap);
    send_word(c3, gap);
    send_byte(ck, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ts", ts, 128'h0);
    check("rst_cnt", 128'(frame_cnt), 128'h0);
    check("rst_pulses", {125'h0, frame_valid, chk_err, timeout_err}, 128'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: good frame, back-to-back bytes
    snap();
    send_frame(32'h1, 32'h2, 32'h3, 32'h4, 8'h04, 0);
    check("t1_valid_latency", 128'(frame_valid), 128'h1);
    check("t1_ts", ts, F1_TS);
    check("t1_cnt", 128'(frame_cnt), 128'd1);
    repeat (3) @(negedge clk);
    check("t1_valid_once", 128'(tot_valid - s_valid), 128'd1);
    check("t1_no_chk_err", 128'(tot_chk - s_chk), 128'd0);

    // 2: bad checksum
    snap();
    send_frame(32'h1, 32'h2, 32'h3, 32'h4, 8'h05, 1);
    check("t2_chk_err_latency", 128'(chk_err), 128'h1);
    repeat (3) @(negedge clk);
    check("t2_chk_err_once", 128'(tot_chk - s_chk), 128'd1);
    check("t2_no_valid", 128'(tot_valid - s_valid), 128'd0);
    check("t2_ts_kept", ts, F1_TS);
    check("t2_cnt_kept", 128'(frame_cnt), 128'd1);

    // 3: junk then good frame
    snap();
    send_byte(8'h3C, 0);
    send_byte(8'hFF, 2);
    send_byte(8'h00, 0);
    send_frame(32'h1, 32'h2, 32'h3, 32'h4, 8'h04, 0);
    repeat (3) @(negedge clk);
    check("t3_valid_once", 128'(tot_valid - s_valid), 128'd1);
    check("t3_cnt", 128'(frame_cnt), 128'd2);
    check("t3_ts", ts, F1_TS);

    // 4: sync value inside payload is data
    snap();
    send_frame(32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 8'h00, 3);
    repeat (3) @(negedge clk);
    check("t4_ch0", 128'(ts[31:0]), 128'hA5A5A5A5);
    check("t4_ts", ts, 128'h00000000_00000000_00000000_A5A5A5A5);
    check("t4_valid_once", 128'(tot_valid - s_valid), 128'd1);
    check("t4_cnt", 128'(frame_cnt), 128'd3);

    // 5: stall after sync + 5 bytes (bytes are the start of frame 1)
    snap();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
`ifdef TRIGG_FRAME_TIMEOUT_EN
    repeat (TO - 1) @(negedge clk);
    check("t5_no_early_timeout", 128'(tot_to - s_to), 128'd0);
    @(negedge clk);
    check("t5_timeout_pulse", 128'(timeout_err), 128'h1);
    repeat (5) @(negedge clk);
    check("t5_timeout_once", 128'(tot_to - s_to), 128'd1);
    check("t5_ts_kept", ts, 128'h00000000_00000000_00000000_A5A5A5A5);
    snap();
    send_frame(32'h1, 32'h2, 32'h3, 32'h4, 8'h04, 0);
`else
    repeat (TO + 50) @(negedge clk);
    check("t5_no_timeout", 128'(tot_to - s_to), 128'd0);
    check("t5_ts_kept", ts, 128'h00000000_00000000_00000000_A5A5A5A5);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h3, 0);
    send_word(32'h4, 0);
    send_byte(8'h04, 0);
`endif
    repeat (3) @(negedge clk);
    check("t5_frame_after", ts, F1_TS);
    check("t5_cnt", 128'(frame_cnt), 128'd4);
    check("t5_valid_once", 128'(tot_valid - s_valid), 128'd1);

    // 6: asynchronous reset after 8 payload bytes
    send_byte(8'hA5, 0);
    send_word(32'h1, 0);
    send_word(32'h2, 0);
    #2 reset_n = 1'b0;
    #1 check("t6_async_ts", ts, 128'h0);
    repeat (2) @(negedge clk);
    check("t6_rst_cnt", 128'(frame_cnt), 128'h0);
    check("t6_rst_pulses", {125'h0, frame_valid, chk_err, timeout_err}, 128'h0);
    reset_n = 1'b1;
    @(negedge clk);
    snap();
    send_frame(32'h1, 32'h2, 32'h3, 32'h4, 8'h04, 0);
    repeat (3) @(negedge clk);
    check("t6_cnt", 128'(frame_cnt), 128'd1);
    check("t6_ts", ts, F1_TS);
    check("t6_valid_once", 128'(tot_valid - s_valid), 128'd1);

    check("pulses_exclusive", 128'(tot_multi), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
